sync_fifo_flags: RTL and testbench
==================================

SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 8, giving the data word width in bits.
REQ-002 The block SHALL have the parameter ADDRESS, default 3, giving the pointer address width; DEPTH SHALL equal 2**ADDRESS.
REQ-003 The block SHALL have the parameter DEPTH, default 8, giving the storage entry count.
REQ-004 The block SHALL have the parameter AF_LEVEL, default 6, giving the ALMOST_FULL threshold; legal range 1..DEPTH-1.
REQ-005 The block SHALL have the parameter AE_LEVEL, default 2, giving the ALMOST_EMPTY threshold; legal range 1..DEPTH-1.
REQ-006 The block SHALL have the parameter FWFT, default 0, selecting the read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-007 The block SHALL have one clock and an asynchronous, active-high reset; the clock is CLK (input, 1 bit, rising edge) and the reset is RST (input, 1 bit).
REQ-008 W_INC  input  1  write request.
REQ-009 WR_DATA  input  WIDTH  write data.
REQ-010 R_INC  input  1  read/pop request.
REQ-011 CLR_ERR  input  1  synchronous clear of the sticky error flags.
REQ-012 RD_DATA  output  WIDTH  read data.
REQ-013 RD_VALID  output  1  RD_DATA qualifier.
REQ-014 FULL, EMPTY  output  1 each  occupancy flags.
REQ-015 ALMOST_FULL, ALMOST_EMPTY  output  1 each  threshold flags.
REQ-016 COUNT  output  ADDRESS+1  current occupancy, 0..DEPTH.
REQ-017 OVERFLOW, UNDERFLOW  output  1 each  sticky error flags.

Function
REQ-018 Storage SHALL use ADDRESS+1-bit write/read pointers; the MSB distinguishes wrap and the low ADDRESS bits address memory.
REQ-019 A write SHALL be accepted at a rising edge iff W_INC=1 and FULL=0: WR_DATA is stored at wptr and wptr increments mod 2**(ADDRESS+1).
REQ-020 A read SHALL be accepted at a rising edge iff R_INC=1 and EMPTY=0: rptr increments mod 2**(ADDRESS+1).
REQ-021 Acceptance SHALL be decided on the pre-edge flags; when FULL=1, a simultaneous read and write SHALL accept the read only; when EMPTY=1, they SHALL accept the write only.
REQ-022 COUNT SHALL be a register: +1 on a write only, -1 on a read only, unchanged when both or neither are accepted; COUNT SHALL always equal wptr-rptr.
REQ-023 The flags SHALL be derived from the COUNT register:
- FULL = (COUNT==DEPTH)
- EMPTY = (COUNT==0)
- ALMOST_FULL = (COUNT>=AF_LEVEL)
- ALMOST_EMPTY = (COUNT<=AE_LEVEL)
REQ-024 In FWFT=0 mode, an accepted read SHALL load mem[rptr] into the RD_DATA register at that edge and drive RD_VALID=1 for exactly the following cycle; otherwise RD_VALID=0 and RD_DATA SHALL hold its value. Latency is 1 cycle.
REQ-025 In FWFT=1 mode, RD_DATA SHALL equal mem[rptr] combinationally and RD_VALID SHALL equal ~EMPTY; R_INC acts as a pop. A word written into an empty FIFO SHALL appear one cycle after its write edge.
REQ-026 A rejected write (W_INC=1, FULL=1) SHALL set OVERFLOW; a rejected read (R_INC=1, EMPTY=1) SHALL set UNDERFLOW; neither SHALL alter pointers, COUNT or memory.
REQ-027 CLR_ERR=1 SHALL clear both error flags at the next edge; a new error in the same cycle SHALL take priority and leave its flag set.
REQ-028 Wrap-around SHALL be seamless: after 2*DEPTH writes and reads, data order and flags SHALL be unaffected.

Reset
REQ-029 While RST=1, independent of CLK, the block SHALL hold: wptr=rptr=0, COUNT=0, EMPTY=1, ALMOST_EMPTY=1, FULL=0, ALMOST_FULL=0, RD_VALID=0, RD_DATA=0, OVERFLOW=0, UNDERFLOW=0.
REQ-030 Memory contents SHALL not be reset; reset mid-operation SHALL discard all stored words, and the first accepted write after release SHALL be the next word read.

Verification
REQ-031 Defaults, fill: write 0x01..0x08 on consecutive cycles -> COUNT steps 1..8, ALMOST_FULL rises when COUNT=6, FULL=1 after the 8th edge, ALMOST_EMPTY falls when COUNT=3.
REQ-032 Full, W_INC=1 with 0xAA -> OVERFLOW=1, COUNT=8, and data read back is still 0x01..0x08; then CLR_ERR=1 -> OVERFLOW=0.
REQ-033 FWFT=0: drain 8 words -> RD_VALID pulses one cycle after each R_INC with 0x01..0x08, and EMPTY=1 after the last; a further R_INC -> UNDERFLOW=1 and RD_DATA holds 0x08.
REQ-034 Simultaneous W_INC/R_INC at COUNT=4 for 20 cycles (wrapping pointers) -> COUNT stays 4 and output order matches input order.
REQ-035 FWFT=1: write 0x5A into an empty FIFO -> RD_VALID=1 and RD_DATA=0x5A on the next cycle with no R_INC; R_INC -> EMPTY=1.
REQ-036 RST asserted asynchronously mid-cycle at COUNT=5 -> all outputs immediately take the REQ-029 values; after release, write 0x33 then read -> 0x33.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with occupancy/threshold flags, sticky error flags and a
// selectable registered or first-word-fall-through read port.
module sync_fifo_flags #(
  parameter int WIDTH    = 8,
  parameter int ADDRESS  = 3,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               W_INC,
  input  logic [WIDTH-1:0]   WR_DATA,
  input  logic               R_INC,
  input  logic               CLR_ERR,
  output logic [WIDTH-1:0]   RD_DATA,
  output logic               RD_VALID,
  output logic               FULL,
  output logic               EMPTY,
  output logic               ALMOST_FULL,
  output logic               ALMOST_EMPTY,
  output logic [ADDRESS:0]   COUNT,
  output logic               OVERFLOW,
  output logic               UNDERFLOW
);

  localparam int PW = ADDRESS + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             wr_en, rd_en;
  logic [ADDRESS-1:0] waddr, raddr;

  // Flags come straight off the count register, so they are glitch-free.
  assign FULL         = (count_q == DEPTH_C);
  assign EMPTY        = (count_q == '0);
  assign ALMOST_FULL  = (count_q >= AF_C);
  assign ALMOST_EMPTY = (count_q <= AE_C);
  assign COUNT        = count_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = unf_q;

  assign wr_en = W_INC & ~FULL;
  assign rd_en = R_INC & ~EMPTY;
  assign waddr = wptr_q[ADDRESS-1:0];
  assign raddr = rptr_q[ADDRESS-1:0];

  always_comb begin
    wptr_d  = wptr_q + PW'(wr_en);
    rptr_d  = rptr_q + PW'(rd_en);
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase
    // A fresh error wins over a clear in the same cycle.
    ovf_d = (W_INC & FULL)  | (ovf_q & ~CLR_ERR);
    unf_d = (R_INC & EMPTY) | (unf_q & ~CLR_ERR);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[waddr] <= WR_DATA;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is forced to zero while empty so stale memory never leaks out.
      assign RD_VALID = ~EMPTY;
      assign RD_DATA  = EMPTY ? '0 : mem_q[raddr];
    end else begin : g_reg
      logic [WIDTH-1:0] rd_data_q;
      logic             rd_valid_q;
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_en;
          if (rd_en) rd_data_q <= mem_q[raddr];
        end
      end
      assign RD_VALID = rd_valid_q;
      assign RD_DATA  = rd_data_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Checks a registered-read and an FWFT instance, driven in lockstep, against a
// queue-based model every cycle, plus directed literal expectations.
module tb_sync_fifo_flags;
  localparam int W = 8, DEP = 8, AF = 6, AE = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic w_inc = 0, r_inc = 0, clr = 0;
  logic [W-1:0] wdata = '0;

  logic [W-1:0] rd0, rd1;
  logic [3:0]   cnt0, cnt1;
  logic v0, v1, f0, f1, e0, e1, af0, af1, ae0, ae1, ov0, ov1, un0, un1;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.WIDTH(W), .ADDRESS(3), .DEPTH(DEP), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) d0 (
    .CLK(clk), .RST(rst), .W_INC(w_inc), .WR_DATA(wdata), .R_INC(r_inc), .CLR_ERR(clr),
    .RD_DATA(rd0), .RD_VALID(v0), .FULL(f0), .EMPTY(e0), .ALMOST_FULL(af0), .ALMOST_EMPTY(ae0),
    .COUNT(cnt0), .OVERFLOW(ov0), .UNDERFLOW(un0));

  sync_fifo_flags #(.WIDTH(W), .ADDRESS(3), .DEPTH(DEP), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) d1 (
    .CLK(clk), .RST(rst), .W_INC(w_inc), .WR_DATA(wdata), .R_INC(r_inc), .CLR_ERR(clr),
    .RD_DATA(rd1), .RD_VALID(v1), .FULL(f1), .EMPTY(e1), .ALMOST_FULL(af1), .ALMOST_EMPTY(ae1),
    .COUNT(cnt1), .OVERFLOW(ov1), .UNDERFLOW(un1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: FIFO contents as a queue, outputs derived from its size.
  logic [W-1:0] q[$];
  bit  m_ovf, m_unf, m_vld;
  logic [W-1:0] m_data;

  always @(posedge clk or posedge rst) begin
    int n;
    bit wa, ra;
    if (rst) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_vld = 0; m_data = '0;
    end else begin
      n  = q.size();
      wa = w_inc && (n != DEP);
      ra = r_inc && (n != 0);
      m_vld = ra;
      if (ra) m_data = q.pop_front();
      if (wa) q.push_back(wdata);
      if (w_inc && n == DEP) m_ovf = 1; else if (clr) m_ovf = 0;
      if (r_inc && n == 0)   m_unf = 1; else if (clr) m_unf = 0;
    end
  end

  always @(negedge clk) begin
    int n;
    n = q.size();
    chk("count0", 32'(cnt0), n);          chk("count1", 32'(cnt1), n);
    chk("full0", f0, n == DEP);           chk("full1", f1, n == DEP);
    chk("empty0", e0, n == 0);            chk("empty1", e1, n == 0);
    chk("afull0", af0, n >= AF);          chk("afull1", af1, n >= AF);
    chk("aempty0", ae0, n <= AE);         chk("aempty1", ae1, n <= AE);
    chk("ovf0", ov0, m_ovf);              chk("ovf1", ov1, m_ovf);
    chk("unf0", un0, m_unf);              chk("unf1", un1, m_unf);
    chk("rvalid0", v0, m_vld);
    chk("rdata0", rd0, m_data);
    chk("rvalid1", v1, n != 0);
    if (n != 0) chk("rdata1", rd1, q[0]);
  end

  // Inputs are applied 1 time unit after a rising edge and consumed at the next one.
  task automatic step(input bit w, input logic [W-1:0] d, input bit r, input bit c);
    w_inc = w; wdata = d; r_inc = r; clr = c;
    @(posedge clk); #1;
    w_inc = 0; r_inc = 0; clr = 0;
  endtask

  initial begin
    logic [W-1:0] exp_rd;
    #3;
    chk("rst_count", 32'(cnt0), 0);  chk("rst_empty", e0, 1);  chk("rst_aempty", ae0, 1);
    chk("rst_full", f0, 0);          chk("rst_afull", af0, 0); chk("rst_rvalid", v0, 0);
    chk("rst_rdata", rd0, 0);        chk("rst_ovf", ov0, 0);   chk("rst_unf", un0, 0);
    chk("rst_rvalid1", v1, 0);       chk("rst_rdata1", rd1, 0);
    @(posedge clk); #1; rst = 0;

    // Fill 0x01..0x08.
    for (int i = 1; i <= 8; i++) begin
      step(1, W'(i), 0, 0);
      chk("fill_count", 32'(cnt0), i);
      chk("fill_afull", af0, i >= 6);
      chk("fill_aempty", ae0, i <= 2);
      chk("fill_full", f0, i == 8);
    end
    // Overflow, then clear.
    step(1, 8'hAA, 0, 0);
    chk("ovf_set", ov0, 1); chk("ovf_count", 32'(cnt0), 8); chk("ovf_set1", ov1, 1);
    step(0, 0, 0, 1);
    chk("ovf_clr", ov0, 0);
    // Drain with registered reads; FWFT head is visible before each pop.
    for (int i = 1; i <= 8; i++) begin
      chk("fwft_head", rd1, i);
      step(0, 0, 1, 0);
      chk("drain_valid", v0, 1);
      chk("drain_data", rd0, i);
    end
    chk("drain_empty", e0, 1);
    step(0, 0, 0, 0);
    chk("valid_pulse", v0, 0);
    step(0, 0, 1, 0);
    chk("unf_set", un0, 1); chk("unf_hold", rd0, 8'h08); chk("unf_novalid", v0, 0);
    step(0, 0, 0, 1);
    chk("unf_clr", un0, 0);

    // Steady state at COUNT=4 with simultaneous push/pop across pointer wrap.
    for (int i = 0; i < 4; i++) step(1, W'(8'h10 + i), 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, W'(8'h20 + i), 1, 0);
      exp_rd = (i < 4) ? W'(8'h10 + i) : W'(8'h20 + i - 4);
      chk("ss_count", 32'(cnt0), 4);
      chk("ss_order", rd0, exp_rd);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    chk("ss_empty", e0, 1);

    // FWFT: word appears without a pop, pop empties.
    step(1, 8'h5A, 0, 0);
    chk("fwft_valid", v1, 1); chk("fwft_data", rd1, 8'h5A);
    step(0, 0, 1, 0);
    chk("fwft_empty", e1, 1); chk("fwft_novalid", v1, 0);

    // Asynchronous reset mid-cycle at COUNT=5.
    for (int i = 0; i < 5; i++) step(1, W'(8'h40 + i), 0, 0);
    chk("pre_rst_count", 32'(cnt0), 5);
    #2 rst = 1; #1;
    chk("arst_count", 32'(cnt0), 0); chk("arst_empty", e0, 1); chk("arst_aempty", ae0, 1);
    chk("arst_full", f0, 0);         chk("arst_rdata", rd0, 0); chk("arst_valid1", v1, 0);
    @(posedge clk); #1; rst = 0;
    step(1, 8'h33, 0, 0);
    chk("post_rst_fwft", rd1, 8'h33);
    step(0, 0, 1, 0);
    chk("post_rst_valid", v0, 1); chk("post_rst_data", rd0, 8'h33);

    // Randomised traffic in phases biased towards filling, draining and balance.
    for (int ph = 0; ph < 12; ph++) begin
      for (int i = 0; i < 150; i++) begin
        bit w, r;
        case (ph % 3)
          0: begin w = ($urandom_range(0, 9) < 8); r = ($urandom_range(0, 9) < 2); end
          1: begin w = ($urandom_range(0, 9) < 2); r = ($urandom_range(0, 9) < 8); end
          default: begin w = $urandom_range(0, 1); r = $urandom_range(0, 1); end
        endcase
        step(w, W'($urandom), r, ($urandom_range(0, 19) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
